// File: rtl/vc_wrr_arbiter.sv
// Weighted round-robin pop scheduler from two VC FIFOs into two destination FIFOs.
// Define VC_STRICT_PRIO_EN for fixed VC0-over-VC1 priority; weights and credits are then ignored.
module vc_wrr_arbiter #(
    parameter int BW       = 6,
    parameter int DEST_BIT = 4,
    parameter int WGT_W    = 4
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             arb_en,
    input  logic             VC0_empty,
    input  logic [BW-1:0]    VC0_data,
    input  logic             VC1_empty,
    input  logic [BW-1:0]    VC1_data,
    input  logic             D0_pause,
    input  logic             D1_pause,
    input  logic [WGT_W-1:0] Weight_VC0,
    input  logic [WGT_W-1:0] Weight_VC1,
    output logic             VC0_pop,
    output logic             VC1_pop,
    output logic [BW-1:0]    D_data_out,
    output logic             D0_push,
    output logic             D1_push,
    output logic [1:0]       owner
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SERVE0 = 2'b01,
        SERVE1 = 2'b10
    } state_t;

    state_t                  state, state_nxt;
    logic [WGT_W-1:0]        cnt, cnt_nxt;
    logic [1:0]              vc_empty;
    logic [1:0][BW-1:0]      vc_data;
    logic [1:0][WGT_W-1:0]   wgt;
    logic [1:0][WGT_W-1:0]   ld_val;
    logic [1:0]              dst_pause;
    logic [1:0]              elig;
    logic [1:0]              gnt;
    logic [BW-1:0]           win;
    logic                    cur, oth;

    assign vc_empty  = {VC1_empty, VC0_empty};
    assign vc_data   = {VC1_data, VC0_data};
    assign wgt       = {Weight_VC1, Weight_VC0};
    assign dst_pause = {D1_pause, D0_pause};

    // Per-VC eligibility and quota reload value (weight 0 behaves as 1).
    for (genvar i = 0; i < 2; i++) begin : g_vc
        assign elig[i]   = arb_en & ~vc_empty[i] & ~dst_pause[vc_data[i][DEST_BIT]];
        assign ld_val[i] = (wgt[i] == '0) ? '0 : wgt[i] - 1'b1;
    end

    assign cur = (state == SERVE1);
    assign oth = ~cur;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        gnt       = 2'b00;
`ifdef VC_STRICT_PRIO_EN
        cnt_nxt = '0;
        if (elig[0]) begin
            gnt       = 2'b01;
            state_nxt = SERVE0;
        end else if (elig[1]) begin
            gnt       = 2'b10;
            state_nxt = SERVE1;
        end
`else
        case (state)
            IDLE: begin
                if (elig[0]) begin
                    gnt       = 2'b01;
                    state_nxt = SERVE0;
                    cnt_nxt   = ld_val[0];
                end else if (elig[1]) begin
                    gnt       = 2'b10;
                    state_nxt = SERVE1;
                    cnt_nxt   = ld_val[1];
                end
            end
            SERVE0, SERVE1: begin
                // A blocked owner yields at once and forfeits leftover credits.
                if (cnt != '0 && elig[cur]) begin
                    gnt[cur] = 1'b1;
                    cnt_nxt  = cnt - 1'b1;
                end else if (elig[oth]) begin
                    gnt[oth]  = 1'b1;
                    state_nxt = oth ? SERVE1 : SERVE0;
                    cnt_nxt   = ld_val[oth];
                end else if (elig[cur]) begin
                    gnt[cur] = 1'b1;
                    cnt_nxt  = ld_val[cur];
                end
            end
            default: state_nxt = IDLE;
        endcase
`endif
    end

    assign VC0_pop = gnt[0] & reset_L;
    assign VC1_pop = gnt[1] & reset_L;
    assign owner   = state;
    assign win     = vc_data[gnt[1]];

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            D_data_out <= '0;
            D0_push    <= 1'b0;
            D1_push    <= 1'b0;
        end else begin
            D0_push <= (|gnt) & ~win[DEST_BIT];
            D1_push <= (|gnt) &  win[DEST_BIT];
            if (|gnt)
                D_data_out <= win;
        end
    end

endmodule

// File: tb/tb_vc_wrr_arbiter.sv
// Bench for vc_wrr_arbiter: FIFO queues plus a quota/run-length reference model, directed then random.
module tb_vc_wrr_arbiter;
    localparam int BW = 6;
    localparam int DB = 4;
    localparam int WW = 4;

    logic          clk, reset_L, arb_en;
    logic          VC0_empty, VC1_empty, D0_pause, D1_pause;
    logic [BW-1:0] VC0_data, VC1_data, D_data_out;
    logic [WW-1:0] Weight_VC0, Weight_VC1;
    logic          VC0_pop, VC1_pop, D0_push, D1_push;
    logic [1:0]    owner;

    vc_wrr_arbiter #(.BW(BW), .DEST_BIT(DB), .WGT_W(WW)) dut (
        .clk(clk), .reset_L(reset_L), .arb_en(arb_en),
        .VC0_empty(VC0_empty), .VC0_data(VC0_data),
        .VC1_empty(VC1_empty), .VC1_data(VC1_data),
        .D0_pause(D0_pause), .D1_pause(D1_pause),
        .Weight_VC0(Weight_VC0), .Weight_VC1(Weight_VC1),
        .VC0_pop(VC0_pop), .VC1_pop(VC1_pop),
        .D_data_out(D_data_out), .D0_push(D0_push), .D1_push(D1_push),
        .owner(owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [BW-1:0] q0[$];
    logic [BW-1:0] q1[$];

    // Reference: current owner, grants used in this run, quota captured at run start.
    int            m_cur, m_used, m_quota;
    logic [BW-1:0] m_data;
    bit            m_p0, m_p1;
    int            n_vec, n_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input int vc, input int n, input int dest);
        logic [BW-1:0] w;
        for (int k = 0; k < n; k++) begin
            w = BW'($urandom);
            if (dest >= 0) w[DB] = dest[0];
            if (vc == 0) q0.push_back(w); else q1.push_back(w);
        end
    endtask

    function automatic int quota_of(input int vc);
        int w;
        w = (vc == 0) ? int'(Weight_VC0) : int'(Weight_VC1);
        return (w == 0) ? 1 : w;
    endfunction

    // One clock: present FIFO heads, check, advance the model, pop queues.
    task automatic cyc();
        bit            e[2];
        int            g, ord0, ord1, own;
        logic [BW-1:0] w;
        VC0_empty = (q0.size() == 0);
        VC0_data  = VC0_empty ? BW'($urandom) : q0[0];
        VC1_empty = (q1.size() == 0);
        VC1_data  = VC1_empty ? BW'($urandom) : q1[0];
        #1;
        if (!reset_L) begin
            m_cur = -1; m_used = 0; m_quota = 0;
            m_data = '0; m_p0 = 1'b0; m_p1 = 1'b0;
        end
        own = (m_cur < 0) ? 0 : (m_cur == 0 ? 1 : 2);
        chk("owner", 32'(owner), 32'(own));
        chk("D_data_out", 32'(D_data_out), 32'(m_data));
        chk("D0_push", 32'(D0_push), 32'(m_p0));
        chk("D1_push", 32'(D1_push), 32'(m_p1));
        g = -1;
        if (reset_L) begin
            e[0] = arb_en && q0.size() > 0 && !(q0[0][DB] ? D1_pause : D0_pause);
            e[1] = arb_en && q1.size() > 0 && !(q1[0][DB] ? D1_pause : D0_pause);
`ifdef VC_STRICT_PRIO_EN
            if (e[0]) g = 0; else if (e[1]) g = 1;
            if (g >= 0) m_cur = g;
`else
            if (m_cur >= 0 && m_used < m_quota && e[m_cur]) begin
                g = m_cur;
                m_used++;
            end else begin
                ord0 = (m_cur < 0) ? 0 : 1 - m_cur;
                ord1 = 1 - ord0;
                if (e[ord0]) g = ord0; else if (e[ord1]) g = ord1;
                if (g >= 0) begin
                    m_cur = g; m_quota = quota_of(g); m_used = 1;
                end
            end
`endif
        end
        chk("VC0_pop", 32'(VC0_pop), 32'(g == 0));
        chk("VC1_pop", 32'(VC1_pop), 32'(g == 1));
        if (reset_L) begin
            if (g >= 0) begin
                w = (g == 0) ? q0.pop_front() : q1.pop_front();
                m_data = w; m_p0 = !w[DB]; m_p1 = w[DB];
            end else begin
                m_p0 = 1'b0; m_p1 = 1'b0;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        m_cur = -1; m_used = 0; m_quota = 0;
        m_data = '0; m_p0 = 1'b0; m_p1 = 1'b0;
        reset_L = 1'b0; arb_en = 1'b1;
        D0_pause = 1'b0; D1_pause = 1'b0;
        Weight_VC0 = 4'd1; Weight_VC1 = 4'd1;
        VC0_empty = 1'b1; VC1_empty = 1'b1; VC0_data = '0; VC1_data = '0;
        @(negedge clk);

        // Reset with both VCs holding data, then first pop on VC0.
        fill(0, 4, 0); fill(1, 4, 1);
        repeat (3) cyc();
        reset_L = 1'b1;
        repeat (10) cyc();

        // 3:1 ratio, all to D0.
        Weight_VC0 = 4'd3; Weight_VC1 = 4'd1;
        fill(0, 8, 0); fill(1, 8, 0);
        repeat (18) cyc();

        // Zero weights alternate 1:1.
        Weight_VC0 = 4'd0; Weight_VC1 = 4'd0;
        fill(0, 4, -1); fill(1, 4, -1);
        repeat (10) cyc();

        // VC0 blocked by D1 pause; VC1 keeps flowing to D0.
        Weight_VC0 = 4'd2; Weight_VC1 = 4'd2;
        fill(0, 3, 1); fill(1, 6, 0);
        D1_pause = 1'b1;
        repeat (5) cyc();
        D1_pause = 1'b0;
        repeat (8) cyc();

        // Freeze mid-quota, then resume.
        Weight_VC0 = 4'd4; Weight_VC1 = 4'd2;
        fill(0, 8, 0); fill(1, 8, 1);
        repeat (2) cyc();
        arb_en = 1'b0;
        repeat (3) cyc();
        arb_en = 1'b1;
        repeat (20) cyc();

        // Random traffic, pauses, enable drops and weight changes.
        repeat (400) begin
            if ($urandom_range(0, 1) == 0 && q0.size() < 8) fill(0, 1, -1);
            if ($urandom_range(0, 1) == 0 && q1.size() < 8) fill(1, 1, -1);
            D0_pause = ($urandom_range(0, 3) == 0);
            D1_pause = ($urandom_range(0, 3) == 0);
            arb_en   = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) Weight_VC0 = WW'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) Weight_VC1 = WW'($urandom_range(0, 15));
            cyc();
        end

        // Reset while a push is registered: cleared immediately.
        D0_pause = 1'b0; D1_pause = 1'b0; arb_en = 1'b1;
        fill(0, 3, 0); fill(1, 3, 1);
        cyc();
        reset_L = 1'b0;
        cyc();
        reset_L = 1'b1;
        repeat (8) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/vc_wrr_arbiter.md
# vc_wrr_arbiter

- Weighted round-robin scheduler between the VC0 and VC1 virtual-channel FIFOs and the D0/D1 destination FIFOs of the QoS interconnect.
- Pops the head word of one VC FIFO per cycle and routes it to D0 or D1 by its destination bit.
- Holds off any VC whose head word targets a destination asserting pause (almost-full).
- Enabled by the init/active control of the system state machine.

## Interface
- BW, 6, data word width.
- DEST_BIT, 4, bit of the data word selecting destination (0 = D0, 1 = D1).
- WGT_W, 4, width of weights and credit counter.

- clk  input  1  single clock, all state on rising edge.
- reset_L  input  1  reset, asynchronous and active-low.
- arb_en  input  1  arbitration enable (driven from active_out); 0 freezes scheduling.
- VC0_empty  input  1  VC0 FIFO empty.
- VC0_data  input  BW  VC0 head word, valid whenever VC0_empty = 0 (first-word fall-through).
- VC1_empty  input  1  VC1 FIFO empty.
- VC1_data  input  BW  VC1 head word.
- D0_pause  input  1  D0 FIFO almost-full.
- D1_pause  input  1  D1 FIFO almost-full.
- Weight_VC0  input  WGT_W  consecutive-grant quota for VC0; 0 treated as 1.
- Weight_VC1  input  WGT_W  quota for VC1; 0 treated as 1.
- VC0_pop  output  1  combinational pop to VC0.
- VC1_pop  output  1  combinational pop to VC1.
- D_data_out  output  BW  registered word to destinations.
- D0_push  output  1  registered write strobe to D0.
- D1_push  output  1  registered write strobe to D1.
- owner  output  2  current FSM state (00 IDLE, 01 SERVE0, 10 SERVE1).

## Operation
- Eligibility: elig_x = arb_en & !VCx_empty & !pause[VCx_data[DEST_BIT]].
- State: FSM {IDLE, SERVE0, SERVE1} plus credit counter cnt (WGT_W bits).
- At most one pop per cycle; grant g is computed combinationally from state, cnt and elig.
- IDLE:
  - If elig0, grant VC0, go to SERVE0, cnt <= W0-1.
  - Else if elig1, grant VC1, go to SERVE1, cnt <= W1-1.
  - Else stay in IDLE.
- SERVEx (other VC is y):
  - If cnt > 0 and elig_x, grant x and decrement cnt.
  - Else if elig_y, grant y, go to SERVEy, cnt <= Wy-1.
  - Else if elig_x, grant x and reload cnt <= Wx-1 (work-conserving).
  - Else no grant; state and cnt hold.
- Weight sampling: weights are sampled only on a load. Changing a weight mid-quota takes effect at the next load.
- Pops: VCx_pop = (g == x); both pops are forced to 0 while reset_L = 0.
- Datapath: the granted head word is registered into D_data_out. Its DEST_BIT drives D0_push or D1_push, never both.
- Idle cycles: with no grant, D0_push = D1_push = 0 and D_data_out holds its last value.
- arb_en = 0: no pops, FSM and cnt frozen. Pushes drop the following cycle.
- Reset values: FSM IDLE, cnt = 0, D_data_out = 0, D0_push = D1_push = 0, owner = 00, pops 0.
- Reset mid-stream: asserting reset clears all state immediately. An in-flight registered word is discarded, with no push.

## Timing
- Pop to push latency: 1 cycle. A pop in cycle N yields push and data at the edge ending cycle N.
- Sustained throughput: 1 word per cycle while any VC is eligible.
- Pause response: a pause sampled in cycle N blocks pops to that destination in cycle N.
  - Up to 1 further push may already be registered, so destinations must assert pause with at least 1 free entry.
- Pause effect on arbitration: a blocked owner yields to the other VC immediately; its unused credits are forfeited.
- Simultaneous elig0 and elig1 in IDLE: VC0 wins.

## Configuration
- VC_STRICT_PRIO_EN defined: the credit counter and weights are ignored.
  - VC0 is granted whenever elig0, else VC1 if elig1.
  - FSM state tracks the last grant; cnt stays 0.
- VC_STRICT_PRIO_EN undefined: weighted round-robin as above.

## Test plan
- Reset behaviour: with reset_L = 0 and both VCs non-empty, pops = 0, pushes = 0, D_data_out = 0, owner = 00. Release reset, then the first pop is on VC0.
- WRR ratio: W0 = 3, W1 = 1, both FIFOs hold 8 words to D0, no pause. Pop pattern is 0,0,0,1,0,0,0,1,... and D0_push is high every cycle from cycle 2.
- Weight 0: W0 = 0, W1 = 0 behaves as 1:1 alternation 0,1,0,1.
- Pause bypass: VC0 head to D1 with D1_pause = 1, VC1 head to D0. VC1 is served every cycle while VC0 gets no pops. Drop D1_pause and VC0 resumes within 1 cycle.
- arb_en gating: drop arb_en in the middle of the VC0 quota. Pops stop the same cycle, pushes stop the next cycle, and cnt holds. Re-enable and the remaining quota completes.
- Strict priority: with VC_STRICT_PRIO_EN, W0 = 1, W1 = 15 and both full, all VC0 words drain before any VC1 pop.
